// File: rtl/conware_engine.sv
// conware_engine: Game-of-Life generation engine.
// Loads a seed board, emits it, then computes each following generation one cell per
// clock and emits each result over a valid/ready handshake.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/in_valid      seed board (cell (x,y) at bit y*WIDTH+x) and its valid
//   in_ready              engine can accept a seed (IDLE or HOLD, gated by rst)
//   run                   level; keep advancing generations while high
//   out_data/out_valid    current generation and its valid
//   out_ready             downstream accepts out_data
//   generation            index of the board in out_data (seed = 0)
module conware_engine #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int WRAP   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*HEIGHT-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      run,
  output logic [WIDTH*HEIGHT-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               generation
);

  localparam int N    = WIDTH * HEIGHT;
  localparam int IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StEmit    = 2'd1;
  localparam logic [1:0] StCompute = 2'd2;
  localparam logic [1:0] StHold    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    cur_q, cur_d;
  logic [N-1:0]    nxt_q, nxt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     gen_q, gen_d;

  // Neighbour count for cell idx_q, always read from cur_q (previous generation).
  logic [3:0]   cnt;
  logic         alive;
  logic [N-1:0] nxt_upd;
  int           cx, cy, nx, ny;
  logic         inb;

  always_comb begin
    cnt = 4'd0;
    cx  = int'(idx_q) % WIDTH;
    cy  = int'(idx_q) / WIDTH;
    nx  = 0;
    ny  = 0;
    inb = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dx == 0 && dy == 0)) begin
          nx  = cx + dx;
          ny  = cy + dy;
          inb = 1'b1;
          if (WRAP != 0) begin
            if (nx < 0) nx = WIDTH - 1;
            else if (nx >= WIDTH) nx = 0;
            if (ny < 0) ny = HEIGHT - 1;
            else if (ny >= HEIGHT) ny = 0;
          end else if (nx < 0 || nx >= WIDTH || ny < 0 || ny >= HEIGHT) begin
            inb = 1'b0;
          end
          if (inb) begin
            if (cur_q[ny * WIDTH + nx]) cnt = cnt + 4'd1;
          end
        end
      end
    end
    alive   = (cnt == 4'd3) | (cur_q[idx_q] & (cnt == 4'd2));
    nxt_upd = nxt_q;
    nxt_upd[idx_q] = alive;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    idx_d   = idx_q;
    gen_d   = gen_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cur_d   = in_data;
          gen_d   = 32'd0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (run) begin
            idx_d   = '0;
            state_d = StCompute;
          end else begin
            state_d = StHold;
          end
        end
      end
      StCompute: begin
        nxt_d = nxt_upd;
        if (idx_q == LastIdx) begin
          // Last cell's result is folded in directly since nxt_q is not yet updated.
          cur_d   = nxt_upd;
          gen_d   = gen_q + 32'd1;
          state_d = StEmit;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StHold: begin
        // A new seed wins over resuming.
        if (in_valid) begin
          cur_d   = in_data;
          gen_d   = 32'd0;
          state_d = StEmit;
        end else if (run) begin
          idx_d   = '0;
          state_d = StCompute;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      nxt_q   <= '0;
      idx_q   <= '0;
      gen_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      idx_q   <= idx_d;
      gen_q   <= gen_d;
    end
  end

  assign in_ready   = ~rst & ((state_q == StIdle) | (state_q == StHold));
  assign out_valid  = (state_q == StEmit);
  assign out_data   = cur_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_conware_engine.sv
// Testbench for conware_engine (4x4): table-driven generation sequences for WRAP=0 and
// WRAP=1 instances, plus directed backpressure/hold and mid-compute reset sequences.
module tb_conware_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        run;
  logic        out_ready;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [15:0] out_data0, out_data1;
  logic [31:0] gen0, gen1;

  logic        sel_wrap;
  logic        s_in_ready, s_valid;
  logic [15:0] s_data;
  logic [31:0] s_gen;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conware_engine #(.WIDTH(4), .HEIGHT(4), .WRAP(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready0),
    .run        (run),
    .out_data   (out_data0),
    .out_valid  (out_valid0),
    .out_ready  (out_ready),
    .generation (gen0)
  );

  conware_engine #(.WIDTH(4), .HEIGHT(4), .WRAP(1)) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready1),
    .run        (run),
    .out_data   (out_data1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready),
    .generation (gen1)
  );

  always_comb begin
    s_in_ready = sel_wrap ? in_ready1 : in_ready0;
    s_valid    = sel_wrap ? out_valid1 : out_valid0;
    s_data     = sel_wrap ? out_data1 : out_data0;
    s_gen      = sel_wrap ? gen1 : gen0;
  end

  typedef struct {
    logic [15:0] seed;
    logic        wrap;
    logic [15:0] g1;
    logic [15:0] g2;
    logic [15:0] g3;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    run       = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load(input logic [15:0] seed);
    in_data  = seed;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for the next emit; cycles = -1 on timeout.
  task automatic wait_emit(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (s_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int          cyc;
    int          bad;
    logic [15:0] exp;

    vecs[0] = '{seed: 16'h0070, wrap: 1'b0, g1: 16'h0222, g2: 16'h0070, g3: 16'h0222};
    vecs[1] = '{seed: 16'hFFFF, wrap: 1'b0, g1: 16'h9009, g2: 16'h0000, g3: 16'h0000};
    vecs[2] = '{seed: 16'h9009, wrap: 1'b1, g1: 16'h9009, g2: 16'h9009, g3: 16'h9009};
    vecs[3] = '{seed: 16'h9009, wrap: 1'b0, g1: 16'h0000, g2: 16'h0000, g3: 16'h0000};

    sel_wrap  = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    run       = 1'b0;
    out_ready = 1'b0;

    // Reset / idle
    repeat (3) tick();
    check("rst_out_valid", 32'(s_valid), 32'd0);
    check("rst_in_ready", 32'(s_in_ready), 32'd0);
    check("rst_generation", s_gen, 32'd0);
    check("rst_out_data", 32'(s_data), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(s_in_ready), 32'd1);

    // Free-running generations from table
    for (int v = 0; v < 4; v++) begin
      sel_wrap = vecs[v].wrap;
      do_reset();
      run       = 1'b1;
      out_ready = 1'b1;
      load(vecs[v].seed);
      check($sformatf("v%0d_g0_valid", v), 32'(s_valid), 32'd1);
      check($sformatf("v%0d_g0_data", v), 32'(s_data), 32'(vecs[v].seed));
      check($sformatf("v%0d_g0_gen", v), s_gen, 32'd0);
      for (int g = 1; g <= 3; g++) begin
        exp = (g == 1) ? vecs[v].g1 : (g == 2) ? vecs[v].g2 : vecs[v].g3;
        wait_emit(cyc);
        check($sformatf("v%0d_g%0d_spacing", v, g), 32'(cyc), 32'd17);
        check($sformatf("v%0d_g%0d_data", v, g), 32'(s_data), 32'(exp));
        check($sformatf("v%0d_g%0d_gen", v, g), s_gen, 32'(g));
      end
    end

    // Backpressure, hold, seed-over-run
    sel_wrap = 1'b0;
    do_reset();
    run       = 1'b1;
    out_ready = 1'b1;
    load(16'h0070);
    wait_emit(cyc);
    out_ready = 1'b0;
    check("bp_g1_spacing", 32'(cyc), 32'd17);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_valid !== 1'b1 || s_data !== 16'h0222 || s_gen !== 32'd1) bad++;
    end
    check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    run       = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_out_valid", 32'(s_valid), 32'd0);
    check("hold_in_ready", 32'(s_in_ready), 32'd1);
    check("hold_out_data", 32'(s_data), 32'h0222);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_valid !== 1'b0 || s_gen !== 32'd1 || s_in_ready !== 1'b1) bad++;
    end
    check("hold_idle_cycles_bad", 32'(bad), 32'd0);
    in_data  = 16'h0001;
    in_valid = 1'b1;
    run      = 1'b1;
    tick();
    in_valid = 1'b0;
    check("hold_seed_valid", 32'(s_valid), 32'd1);
    check("hold_seed_data", 32'(s_data), 32'h0001);
    check("hold_seed_gen", s_gen, 32'd0);
    out_ready = 1'b1;
    wait_emit(cyc);
    check("hold_seed_g1_spacing", 32'(cyc), 32'd17);
    check("hold_seed_g1_data", 32'(s_data), 32'h0000);
    check("hold_seed_g1_gen", s_gen, 32'd1);

    // Reset during COMPUTE (idx = 7 of gen 1)
    do_reset();
    run       = 1'b1;
    out_ready = 1'b1;
    load(16'h0070);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 32'(s_valid), 32'd0);
    check("midrst_out_data", 32'(s_data), 32'h0000);
    check("midrst_gen", s_gen, 32'd0);
    check("midrst_in_ready_gated", 32'(s_in_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("midrst_in_ready", 32'(s_in_ready), 32'd1);
    load(16'h0222);
    check("midrst_seed_data", 32'(s_data), 32'h0222);
    check("midrst_seed_gen", s_gen, 32'd0);
    wait_emit(cyc);
    check("midrst_g1_spacing", 32'(cyc), 32'd17);
    check("midrst_g1_data", 32'(s_data), 32'h0070);
    check("midrst_g1_gen", s_gen, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
